serial_comparator: RTL

Sequential magnitude/equality comparator for two WIDTH-bit operands delivered serially, one bit pair per accepted cycle, MSB first. It is the receiving end of a bit-serial operand link. It reconstructs the comparison outcome the parallel equality comparator produces in one step, and adds greater/less flags. It sits between a serial operand source and any control logic that needs registered EQUALS/GREATER/LESS results with a completion strobe.

---
 rtl/serial_comparator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude/equality comparator. Operands arrive MSB first;
// the first differing bit pair decides the result, which is registered with a done strobe.
module serial_comparator #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            bit_valid,
    input  logic            a_bit,
    input  logic            b_bit,
    output logic            busy,
    output logic            done,
    output logic            equals,
    output logic            greater,
    output logic            less,
    output logic [CntW-1:0] bit_count
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              decided_q, decided_d;
    logic              gt_q, gt_d;
    logic              lt_q, lt_d;
    logic              equals_q, equals_d;
    logic              greater_q, greater_d;
    logic              less_q, less_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        equals_d  = equals_q;
        greater_d = greater_q;
        less_d    = less_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    equals_d  = 1'b0;
                    greater_d = 1'b0;
                    less_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StShift: begin
                if (bit_valid) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (!decided_q && (a_bit != b_bit)) begin
                        decided_d = 1'b1;
                        gt_d      = a_bit;
                        lt_d      = b_bit;
                    end
                    // Results load from the updated flags so the last bit pair still counts.
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        equals_d  = !gt_d && !lt_d;
                        greater_d = gt_d;
                        less_d    = lt_d;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            equals_q  <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            equals_q  <= equals_d;
            greater_q <= greater_d;
            less_q    <= less_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign equals    = equals_q;
    assign greater   = greater_q;
    assign less      = less_q;
    assign bit_count = cnt_q;

endmodule
